addac_core: RTL and testbench



---
 rtl/addac_pkg.sv | 13 +
 rtl/addac_if.sv | 23 ++
 rtl/addac_alu.sv | 28 ++
 rtl/addac_core.sv | 60 ++++++
 tb/tb_addac_core.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/addac_pkg.sv
// Shared width, word type and operation encoding for the addac add/subtract unit.
package addac_pkg;

  localparam int ADDAC_W = 4;

  typedef logic [ADDAC_W-1:0] addac_word_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addac_op_t;

endpackage

// File: rtl/addac_if.sv
// Operand/result bundle of addac_core; master drives operands, slave returns results.
interface addac_if;
  import addac_pkg::*;

  logic        a;
  logic        b;
  addac_word_t c;
  addac_word_t d;
  logic        e;
  addac_word_t saida1;
  addac_word_t saida2;

  modport master (
    output a, b, c, d, e,
    input  saida1, saida2
  );

  modport slave (
    input  a, b, c, d, e,
    output saida1, saida2
  );

endinterface

// File: rtl/addac_alu.sv
// Combinational 4-bit add / subtract-with-carry; subtract is c + ~d + e.
module addac_alu
  import addac_pkg::*;
(
  input  addac_op_t   op,
  input  addac_word_t c,
  input  addac_word_t d,
  input  logic        e,
  output addac_word_t r,
  output logic        carry
);

  addac_word_t       d_eff;
  logic [ADDAC_W:0]  sum;

  always_comb begin
    // NOTE: every always_comb output is assigned up front so no path can infer a latch.
    d_eff = d;
    if (op == OP_SUB) begin
      d_eff = ~d;
    end
    sum = {1'b0, c} + {1'b0, d_eff} + {{ADDAC_W{1'b0}}, e};
  end

  assign r     = sum[ADDAC_W-1:0];
  assign carry = sum[ADDAC_W];

endmodule

// File: rtl/addac_core.sv
// Registered add/subtract result plus running accumulator.
// Define ADDAC_SAT_EN to make the accumulator saturate at 15 instead of wrapping.
module addac_core
  import addac_pkg::*;
(
  input logic   clk,
  input logic   reset,
  addac_if.slave bus
);

  addac_word_t      r;
  logic             alu_carry;
  logic [ADDAC_W:0] acc_sum;
  addac_word_t      acc_next;

  addac_alu u_alu (
    .op    (addac_op_t'(bus.a)),
    .c     (bus.c),
    .d     (bus.d),
    .e     (bus.e),
    .r     (r),
    .carry (alu_carry)
  );

  // The accumulator folds in this cycle's r, not the registered saida1.
  assign acc_sum = {1'b0, bus.saida2} + {1'b0, r};

`ifdef ADDAC_SAT_EN
  logic carry_unused;
  assign carry_unused = alu_carry;

  always_comb begin
    acc_next = acc_sum[ADDAC_W-1:0];
    if (acc_sum[ADDAC_W]) begin
      acc_next = {ADDAC_W{1'b1}};
    end
  end
`else
  logic carry_unused;
  assign carry_unused = alu_carry;

  always_comb begin
    acc_next = acc_sum[ADDAC_W-1:0];
  end
`endif

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.saida1 <= '0;
      bus.saida2 <= '0;
    end else begin
      bus.saida1 <= r;
      if (bus.b) begin
        bus.saida2 <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_addac_core.sv
// Directed and exhaustive checks of addac_core; build with ADDAC_SAT_EN to check saturation.
module tb_addac_core;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  addac_if bus ();

  addac_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one set of inputs, clock it in, and settle past the edge.
  task automatic step(input logic a, input logic b, input logic [3:0] c,
                      input logic [3:0] d, input logic e);
    bus.a = a;
    bus.b = b;
    bus.c = c;
    bus.d = d;
    bus.e = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b1, 1'b1, 4'd9, 4'd6, 1'b1);
    total++;
    if (bus.saida1 !== 4'd0) $display("FAIL reset_saida1 got %0d want 0", bus.saida1);
    else passed++;
    total++;
    if (bus.saida2 !== 4'd0) $display("FAIL reset_saida2 got %0d want 0", bus.saida2);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_add();
    step(1'b0, 1'b0, 4'd5, 4'd3, 1'b0);
    total++;
    if (bus.saida1 !== 4'd8) $display("FAIL add_5_3 got %0d want 8", bus.saida1);
    else passed++;
    total++;
    if (bus.saida2 !== 4'd0) $display("FAIL add_hold_acc got %0d want 0", bus.saida2);
    else passed++;
  endtask

  task automatic test_sub();
    step(1'b1, 1'b0, 4'd5, 4'd3, 1'b1);
    total++;
    if (bus.saida1 !== 4'd2) $display("FAIL sub_5_3_e1 got %0d want 2", bus.saida1);
    else passed++;
    step(1'b1, 1'b0, 4'd5, 4'd3, 1'b0);
    total++;
    if (bus.saida1 !== 4'd1) $display("FAIL sub_5_3_e0 got %0d want 1", bus.saida1);
    else passed++;
    step(1'b1, 1'b0, 4'd3, 4'd5, 1'b1);
    total++;
    if (bus.saida1 !== 4'd14) $display("FAIL sub_3_5_wrap got %0d want 14", bus.saida1);
    else passed++;
  endtask

  task automatic test_carry_drop();
    step(1'b0, 1'b0, 4'd15, 4'd15, 1'b1);
    total++;
    if (bus.saida1 !== 4'd15) $display("FAIL carry_drop got %0d want 15", bus.saida1);
    else passed++;
    total++;
    if (bus.saida2 !== 4'd0) $display("FAIL carry_drop_acc got %0d want 0", bus.saida2);
    else passed++;
  endtask

  task automatic test_accumulate();
    logic [3:0] want2;
`ifdef ADDAC_SAT_EN
    want2 = 4'd15;
`else
    want2 = 4'd0;
`endif
    do_reset();
    step(1'b0, 1'b1, 4'd4, 4'd4, 1'b0);
    total++;
    if (bus.saida2 !== 4'd8) $display("FAIL acc_first got %0d want 8", bus.saida2);
    else passed++;
    step(1'b0, 1'b1, 4'd4, 4'd4, 1'b0);
    total++;
    if (bus.saida2 !== want2) $display("FAIL acc_second got %0d want %0d", bus.saida2, want2);
    else passed++;
    step(1'b0, 1'b0, 4'd1, 4'd2, 1'b0);
    total++;
    if (bus.saida2 !== want2) $display("FAIL acc_hold got %0d want %0d", bus.saida2, want2);
    else passed++;
    total++;
    if (bus.saida1 !== 4'd3) $display("FAIL acc_hold_saida1 got %0d want 3", bus.saida1);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b0, 1'b1, 4'd3, 4'd4, 1'b0);
    total++;
    if (bus.saida2 !== 4'd7) $display("FAIL mid_setup got %0d want 7", bus.saida2);
    else passed++;
    reset = 1'b1;
    step(1'b0, 1'b1, 4'd3, 4'd4, 1'b0);
    reset = 1'b0;
    total++;
    if (bus.saida1 !== 4'd0) $display("FAIL mid_reset_saida1 got %0d want 0", bus.saida1);
    else passed++;
    total++;
    if (bus.saida2 !== 4'd0) $display("FAIL mid_reset_saida2 got %0d want 0", bus.saida2);
    else passed++;
    step(1'b0, 1'b1, 4'd1, 4'd1, 1'b0);
    total++;
    if (bus.saida2 !== 4'd2) $display("FAIL mid_restart_acc got %0d want 2", bus.saida2);
    else passed++;
    total++;
    if (bus.saida1 !== 4'd2) $display("FAIL mid_restart_saida1 got %0d want 2", bus.saida1);
    else passed++;
  endtask

  task automatic test_sweep();
    int exp_r;
    int exp_acc;
    int sum;
    logic [10:0] v;
    do_reset();
    exp_acc = 0;
    for (int i = 0; i < 2048; i++) begin
      v = i[10:0];
      if (v[10]) exp_r = (int'(v[8:5]) + 16 - int'(v[4:1]) - 1 + int'(v[0])) % 16;
      else       exp_r = (int'(v[8:5]) + int'(v[4:1]) + int'(v[0])) % 16;
      if (v[9]) begin
        sum = exp_acc + exp_r;
`ifdef ADDAC_SAT_EN
        exp_acc = (sum > 15) ? 15 : sum;
`else
        exp_acc = sum % 16;
`endif
      end
      step(v[10], v[9], v[8:5], v[4:1], v[0]);
      total++;
      if (bus.saida1 !== exp_r[3:0])
        $display("FAIL sweep_saida1 vec %0d got %0d want %0d", i, bus.saida1, exp_r);
      else passed++;
      total++;
      if (bus.saida2 !== exp_acc[3:0])
        $display("FAIL sweep_saida2 vec %0d got %0d want %0d", i, bus.saida2, exp_acc);
      else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    bus.a  = 1'b0;
    bus.b  = 1'b0;
    bus.c  = 4'd0;
    bus.d  = 4'd0;
    bus.e  = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_carry_drop();
    test_accumulate();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
